// File: rtl/sd_access_arbiter.sv
// sd_access_arbiter: runs SD init, then shares single-block read/write between two requesters round-robin.
module sd_access_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic              sd_init,
  input  logic              init_ok,
  output logic              sd_ren,
  output logic              sd_wen,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              rd_ok,
  input  logic              wr_ok,
  output logic              busy,
  output logic              owner
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {INIT_REQ, INIT_WAIT, IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d, owner_q, owner_d, last_q, last_d;
  logic [1:0]        ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic              init_q, init_d, ren_q, ren_d, wen_q, wen_d, busy_q, busy_d;
  logic              take, grant, ok, expired;
  assign take    = state_q == IDLE && (req0_valid || req1_valid);
  assign grant   = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign ok      = wr_q ? wr_ok : rd_ok;
  assign expired = timer_q == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_REQ;
      timer_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      init_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      init_q  <= init_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_REQ:  state_d = INIT_WAIT;
      INIT_WAIT: state_d = init_ok ? IDLE : expired ? INIT_REQ : INIT_WAIT;
      IDLE:      state_d = take ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT;
      WAIT:      state_d = ok ? IDLE : expired ? INIT_REQ : WAIT;
      default:   state_d = INIT_REQ;
    endcase
  end
  // ok is checked before expiry, so a completion on the last cycle still wins
  always_comb begin
    timer_d = (state_q == INIT_WAIT || state_q == WAIT) ? timer_q + TW'(1) : '0;
    addr_d  = take ? (grant ? req1_addr : req0_addr) : addr_q;
    wr_d    = take ? (grant ? req1_write : req0_write) : wr_q;
    owner_d = take ? grant : owner_q;
    last_d  = take ? grant : last_q;
    ready_d = take ? (grant ? 2'b10 : 2'b01) : 2'b00;
    done_d  = (state_q == WAIT && ok) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    err_d   = (state_q == WAIT && !ok && expired) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    init_d  = state_q == INIT_REQ;
    ren_d   = state_q == ISSUE && !wr_q;
    wen_d   = state_q == ISSUE && wr_q;
    busy_d  = state_d != IDLE;
  end
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign sd_init    = init_q;
  assign sd_ren     = ren_q;
  assign sd_wen     = wen_q;
  assign sd_addr    = addr_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
endmodule

// File: tb/tb_sd_access_arbiter.sv
// tb_sd_access_arbiter: directed checks of init, grants, completion, timeout and reset abort.
module tb_sd_access_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [31:0] req0_addr = '0, req1_addr = '0, sd_addr;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic        sd_init, init_ok = 0, sd_ren, sd_wen, rd_ok = 0, wr_ok = 0, busy, owner;
  int          total = 0, passed = 0;

  sd_access_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .sd_init(sd_init), .init_ok(init_ok), .sd_ren(sd_ren), .sd_wen(sd_wen),
    .sd_addr(sd_addr), .rd_ok(rd_ok), .wr_ok(wr_ok), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic finish_init;
    init_ok = 1; tick; init_ok = 0;
    total++; if (busy !== 1'b0) $display("FAIL init_busy_low: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_reset;
    int pulses;
    tick;
    total++; if ({sd_init, sd_ren, sd_wen, req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err} !== 9'b0) $display("FAIL rst_pulses: got %b exp 0", {sd_init, sd_ren, sd_wen, req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err}); else passed++;
    total++; if ({busy, owner} !== 2'b10) $display("FAIL rst_busy_owner: got %b exp 10", {busy, owner}); else passed++;
    total++; if (sd_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 0", sd_addr); else passed++;
    rst = 0; tick;
    total++; if (sd_init !== 1'b1) $display("FAIL init_pulse: got %b exp 1", sd_init); else passed++;
    pulses = 0;
    for (int i = 1; i < 20; i++) begin tick; if (sd_init) pulses++; end
    tick;
    total++; if (pulses !== 0 || sd_init !== 1'b0) $display("FAIL init_single: got %0d extra exp 0", pulses + sd_init); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL init_busy_high: got %b exp 1", busy); else passed++;
    finish_init;
  endtask

  task automatic test_read;
    req0_valid = 1; req0_write = 0; req0_addr = 32'h10; tick;
    total++; if ({req0_ready, req1_ready, sd_ren} !== 3'b100) $display("FAIL rd_ready: got %b exp 100", {req0_ready, req1_ready, sd_ren}); else passed++;
    req0_valid = 0; tick;
    total++; if ({sd_ren, sd_wen, req0_ready} !== 3'b100) $display("FAIL rd_strobe: got %b exp 100", {sd_ren, sd_wen, req0_ready}); else passed++;
    total++; if (sd_addr !== 32'h10 || owner !== 1'b0) $display("FAIL rd_addr: got %h/%b exp 10/0", sd_addr, owner); else passed++;
    tick; tick;
    total++; if ({req0_done, sd_ren, busy} !== 3'b001) $display("FAIL rd_wait: got %b exp 001", {req0_done, sd_ren, busy}); else passed++;
    rd_ok = 1; tick; rd_ok = 0;
    total++; if ({req0_done, req0_err, req1_done} !== 3'b100) $display("FAIL rd_done: got %b exp 100", {req0_done, req0_err, req1_done}); else passed++;
    tick;
    total++; if ({req0_done, busy} !== 2'b00) $display("FAIL rd_idle: got %b exp 00", {req0_done, busy}); else passed++;
  endtask

  task automatic test_timeout;
    int errs;
    req1_valid = 1; req1_write = 1; req1_addr = 32'hABCD; tick;
    total++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL to_ready: got %b exp 10", {req1_ready, req0_ready}); else passed++;
    req1_valid = 0; tick;
    total++; if ({sd_wen, sd_ren, owner} !== 3'b101 || sd_addr !== 32'hABCD) $display("FAIL to_strobe: got %b/%h exp 101/abcd", {sd_wen, sd_ren, owner}, sd_addr); else passed++;
    errs = 0;
    for (int i = 1; i < 64; i++) begin tick; if (req1_err || req1_done) errs++; end
    total++; if (errs !== 0) $display("FAIL to_early: got %0d exp 0", errs); else passed++;
    tick;
    total++; if ({req1_err, req1_done, req0_err, sd_init} !== 4'b1000) $display("FAIL to_err: got %b exp 1000", {req1_err, req1_done, req0_err, sd_init}); else passed++;
    tick;
    total++; if ({sd_init, req1_err, busy} !== 3'b101) $display("FAIL to_reinit: got %b exp 101", {sd_init, req1_err, busy}); else passed++;
    finish_init;
  endtask

  task automatic test_back_to_back;
    logic exp_p;
    logic [31:0] exp_a;
    req0_write = 0; req0_addr = 32'h100; req1_write = 1; req1_addr = 32'h200;
    req0_valid = 1; req1_valid = 1;
    for (int r = 0; r < 3; r++) begin
      exp_p = (r == 1);
      exp_a = exp_p ? 32'h200 : 32'h100;
      tick;
      total++; if ({req1_ready, req0_ready} !== (exp_p ? 2'b10 : 2'b01)) $display("FAIL b2b_ready%0d: got %b exp port %0d", r, {req1_ready, req0_ready}, exp_p); else passed++;
      if (exp_p) req1_valid = 0; else req0_valid = 0;
      tick;
      total++; if ({sd_wen, sd_ren} !== (exp_p ? 2'b10 : 2'b01) || sd_addr !== exp_a) $display("FAIL b2b_strobe%0d: got %b/%h exp addr %h", r, {sd_wen, sd_ren}, sd_addr, exp_a); else passed++;
      req0_valid = 1; req1_valid = 1;
      tick;
      if (exp_p) wr_ok = 1; else rd_ok = 1;
      tick; wr_ok = 0; rd_ok = 0;
      total++; if ({req1_done, req0_done} !== (exp_p ? 2'b10 : 2'b01) || owner !== exp_p) $display("FAIL b2b_done%0d: got %b owner %b exp port %0d", r, {req1_done, req0_done}, owner, exp_p); else passed++;
      if (r == 2) begin req0_valid = 0; req1_valid = 0; end
    end
    tick;
    total++; if ({busy, req0_ready, req1_ready} !== 3'b000) $display("FAIL b2b_idle: got %b exp 000", {busy, req0_ready, req1_ready}); else passed++;
  endtask

  task automatic test_ok_on_expiry;
    req0_valid = 1; req0_write = 0; req0_addr = 32'h55; tick;
    req0_valid = 0; tick;
    total++; if ({sd_ren, sd_wen} !== 2'b10) $display("FAIL exp_strobe: got %b exp 10", {sd_ren, sd_wen}); else passed++;
    tick; wr_ok = 1; tick; wr_ok = 0;
    total++; if ({req0_done, req0_err, busy} !== 3'b001) $display("FAIL exp_wrok_ignored: got %b exp 001", {req0_done, req0_err, busy}); else passed++;
    for (int i = 0; i < 61; i++) tick;
    rd_ok = 1; tick; rd_ok = 0;
    total++; if ({req0_done, req0_err} !== 2'b10) $display("FAIL exp_ok_wins: got %b exp 10", {req0_done, req0_err}); else passed++;
    tick;
    total++; if ({req0_err, sd_init, busy} !== 3'b000) $display("FAIL exp_after: got %b exp 000", {req0_err, sd_init, busy}); else passed++;
  endtask

  task automatic test_reset_mid;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h77; tick;
    req1_valid = 0; tick;
    total++; if (sd_ren !== 1'b1 || sd_addr !== 32'h77) $display("FAIL mid_strobe: got %b/%h exp 1/77", sd_ren, sd_addr); else passed++;
    tick;
    rst = 1; rd_ok = 1; #1;
    total++; if ({busy, owner, sd_ren, sd_init, req1_done, req1_err} !== 6'b100000 || sd_addr !== 32'h0) $display("FAIL mid_async: got %b/%h exp 100000/0", {busy, owner, sd_ren, sd_init, req1_done, req1_err}, sd_addr); else passed++;
    tick;
    total++; if ({req1_done, req1_err, req0_done, req0_err} !== 4'b0000) $display("FAIL mid_held: got %b exp 0000", {req1_done, req1_err, req0_done, req0_err}); else passed++;
    rst = 0; rd_ok = 0; tick;
    total++; if ({sd_init, req1_done, req1_err} !== 3'b100) $display("FAIL mid_reinit: got %b exp 100", {sd_init, req1_done, req1_err}); else passed++;
    finish_init;
  endtask

  initial begin
    test_reset;
    test_read;
    test_timeout;
    test_back_to_back;
    test_ok_on_expiry;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
